vector_packer: RTL
==================

Name: vector_packer

Overview:
- Transmit side of the lane-vector stream consumed by multiply_and_accumulate.
- Packs a scalar word stream (valid/ready) into VECTOR_SIZE-lane beats, each with a per-lane valid mask and a last flag.
- Feeds dataAIn/dataBIn/validIn/lastIn of the MAC; one instance per operand.
- A start command supplies the total word count and frames the vector.

Parameters:
- VECTOR_SIZE, 8: lanes per output beat.
- DATA_WIDTH, 32: bits per lane/word.
- LEN_WIDTH, 16: width of the length field; max vector length is 2^LEN_WIDTH-1 words.

Ports:
- clkIn  input  1  clock, rising edge.
- rstIn  input  1  asynchronous, active-low reset.
- startIn  input  1  command pulse; sampled only in IDLE.
- lengthIn  input  LEN_WIDTH  total words in the vector; sampled with startIn.
- wordIn  input  DATA_WIDTH  scalar input word.
- wordValidIn  input  1  wordIn valid.
- wordReadyOut  output  1  packer accepts a word this cycle.
- dataOut  output  VECTOR_SIZE*DATA_WIDTH  beat data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- validOut  output  VECTOR_SIZE  per-lane valid mask; nonzero for exactly one cycle per beat.
- lastOut  output  1  final beat of the vector; high only together with a nonzero validOut.
- busyOut  output  1  high in FILL.
- doneOut  output  1  one-cycle pulse at vector completion.

Behaviour:
- Reset (rstIn=0, async): state IDLE; all outputs 0; lane buffer, mask, lane index and remaining count cleared.
- States: IDLE, FILL.
- IDLE:
  - wordReadyOut=0.
  - startIn=1 with lengthIn>0: latch remaining=lengthIn, laneIdx=0, mask=0; go to FILL next edge.
  - startIn=1 with lengthIn=0: stay in IDLE; doneOut=1 next cycle; no beat emitted.
- FILL:
  - wordReadyOut=1 combinationally; no backpressure from the output, because the MAC has no ready.
  - On accept (wordValidIn & wordReadyOut):
    - write wordIn to lane laneIdx;
    - set mask[laneIdx];
    - remaining--, laneIdx++.
  - Beat emission is triggered by an accept when laneIdx==VECTOR_SIZE-1 or remaining==1. On the next cycle:
    - dataOut = lane buffer including the new word;
    - validOut = updated mask;
    - lastOut = (remaining was 1).
    - Latency: 1 cycle from the accepting edge of the beat's final word.
  - After emission: laneIdx=0, mask=0. The output register is separate from the lane buffer, so sustained 1 word/cycle input is supported with no bubbles.
  - Final accept (remaining==1): go to IDLE on the same edge. doneOut pulses in the same cycle as the last beat (validOut/lastOut).
- Full beats have mask all ones. A partial final beat has a mask of contiguous low-order bits, width = lengthIn mod VECTOR_SIZE.
- startIn during FILL is ignored: no relatch, no effect on the stream.
- wordValidIn in IDLE is not accepted (ready=0). The upstream must hold it.
- Idle/non-beat cycles: validOut=0, lastOut=0, doneOut=0. dataOut holds the previous beat value.
- Reset mid-vector: immediate abort; no partial beat emitted; doneOut not pulsed.
- Back-to-back vectors: startIn is accepted in the first IDLE cycle after done. Minimum gap from last accepted word to the next vector's first accepted word is 2 cycles.

Optional Feature:
- Macro: VEC_PACKER_ZERO_PAD_EN
- Defined: lanes with validOut[i]=0 drive zero in dataOut on every beat. The lane buffer is cleared on each emission.
- Undefined: invalid lanes carry whatever the lane buffer held from the previous beat (stale but deterministic). The MAC ignores them via validOut.

Test Plan:
- Reset then idle, wordValidIn=1 -> wordReadyOut=0; validOut=0, lastOut=0, doneOut=0, dataOut=0.
- start length=8, words 1..8 on consecutive cycles:
  - -> one beat with validOut=8'hFF, lastOut=1, lane i = i+1;
  - -> beat 1 cycle after the 8th accept; doneOut in the same cycle.
- start length=11, words 1..11:
  - -> beat 1: mask 8'hFF, lastOut=0;
  - -> beat 2: mask 8'h07, lastOut=1, lanes 0..2 = 9,10,11;
  - -> with ZERO_PAD_EN, lanes 3..7 = 0; without it, lanes 3..7 = 4..8 (stale).
- start length=0 -> no beat; doneOut pulse 1 cycle after startIn; busyOut stays 0.
- length=5 with wordValidIn toggling every other cycle, plus a startIn (length=3) in mid-FILL:
  - -> single beat, mask 8'h1F, lastOut=1, lanes 0..4 = 1..5;
  - -> the second start is ignored.
- rstIn low after 3 of 8 words:
  - -> all outputs 0 immediately, no beat emitted;
  - -> after release, start length=2 yields mask 8'h03 with fresh data only.

Source files
------------

// File: rtl/vector_packer.sv
// vector_packer: packs a scalar valid/ready word stream into lane-vector beats with a per-lane mask and a last flag.
// Optional VEC_PACKER_ZERO_PAD_EN: invalid lanes of every beat read as zero instead of stale data.
module vector_packer #(
  parameter int VECTOR_SIZE = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                              clkIn,
  input  logic                              rstIn,
  input  logic                              startIn,
  input  logic [LEN_WIDTH-1:0]              lengthIn,
  input  logic [DATA_WIDTH-1:0]             wordIn,
  input  logic                              wordValidIn,
  output logic                              wordReadyOut,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataOut,
  output logic [VECTOR_SIZE-1:0]            validOut,
  output logic                              lastOut,
  output logic                              busyOut,
  output logic                              doneOut
);
  localparam int IW = VECTOR_SIZE > 1 ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [0:0] IDLE = 1'b0, FILL = 1'b1;
  logic [0:0] state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [IW-1:0] lane_idx;
  logic [VECTOR_SIZE-1:0] mask, mask_nxt;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] lanes, lanes_nxt;
  logic accept, final_word, emit;
  assign wordReadyOut = state == FILL;
  assign busyOut      = state == FILL;
  assign accept       = wordValidIn & wordReadyOut;
  assign final_word   = remaining == LEN_WIDTH'(1);
  assign emit         = accept & (lane_idx == IW'(VECTOR_SIZE - 1) | final_word);
  assign mask_nxt     = mask | (VECTOR_SIZE'(1) << lane_idx);
  always_comb begin
    lanes_nxt = lanes;
    lanes_nxt[lane_idx*DATA_WIDTH +: DATA_WIDTH] = wordIn;
  end
  // Output register is separate from the lane buffer so a new beat can start filling right after emission.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state     <= IDLE;
      remaining <= '0;
      lane_idx  <= '0;
      mask      <= '0;
      lanes     <= '0;
      dataOut   <= '0;
      validOut  <= '0;
      lastOut   <= 1'b0;
      doneOut   <= 1'b0;
    end else begin
      validOut <= '0;
      lastOut  <= 1'b0;
      doneOut  <= 1'b0;
      if (state == IDLE) begin
        if (startIn && lengthIn != '0) begin
          state     <= FILL;
          remaining <= lengthIn;
          lane_idx  <= '0;
          mask      <= '0;
        end else if (startIn) begin
          doneOut <= 1'b1;
        end
      end else if (accept) begin
        remaining <= remaining - LEN_WIDTH'(1);
        if (emit) begin
          dataOut  <= lanes_nxt;
          validOut <= mask_nxt;
          lastOut  <= final_word;
          doneOut  <= final_word;
          lane_idx <= '0;
          mask     <= '0;
`ifdef VEC_PACKER_ZERO_PAD_EN
          lanes    <= '0;
`else
          lanes    <= lanes_nxt;
`endif
          if (final_word) state <= IDLE;
        end else begin
          lanes    <= lanes_nxt;
          mask     <= mask_nxt;
          lane_idx <= lane_idx + IW'(1);
        end
      end
    end
  end
endmodule
